// File: rtl/sprite_table_loader.sv
// Avalon-MM loader for a double-buffered sprite attribute table. Software fills
// the shadow copy, and a commit copies it to the active copy on the first vblank line.
module sprite_table_loader #(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  VGA_VCOUNT,
  input  logic [4:0]  rd_index,
  output logic [25:0] rd_entry,
  output logic        commit_pending,
  output logic        frame_irq
);

  localparam int unsigned ENTRY_W = 26;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned VCNT_W  = 10;
  localparam int unsigned IDX_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [VCNT_W-1:0] VBLANK_V = VCNT_W'(VBLANK_LINE);

  localparam logic [2:0] ADDR_ENTRY  = 3'd0;
  localparam logic [2:0] ADDR_COMMIT = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0] shadow_q [NUM_SPRITES];
  logic [ENTRY_W-1:0] shadow_d [NUM_SPRITES];
  logic [ENTRY_W-1:0] active_q [NUM_SPRITES];
  logic [ENTRY_W-1:0] active_d [NUM_SPRITES];

  logic [VCNT_W-1:0]  vcount_q, vcount_d;
  logic [FCNT_W-1:0]  frame_count_q, frame_count_d;
  logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               frame_irq_q, frame_irq_d;

  logic             vblank_edge_c;
  logic             entry_wr_c;
  logic             commit_wr_c;
  logic             clear_wr_c;
  logic             bus_rd_c;
  logic             copy_en_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             unused_c;

  // Bus decode; out-of-range entry indices are dropped here.
  always_comb begin
    bus_rd_c      = chipselect && read;
    entry_wr_c    = chipselect && write && (address == ADDR_ENTRY) &&
                    (32'(writedata[31:27]) < NUM_SPRITES);
    commit_wr_c   = chipselect && write && (address == ADDR_COMMIT);
    clear_wr_c    = chipselect && write && (address == ADDR_CLEAR);
    wr_idx_c      = writedata[27 +: IDX_W];
    vblank_edge_c = (vcount_q != VBLANK_V) && (VGA_VCOUNT == VBLANK_V);
    unused_c      = writedata[0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_wr_c)   state_d = ARMED;
      ARMED:   if (vblank_edge_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a commit lands only if it was armed before the edge cycle
  always_comb begin
    copy_en_c   = 1'b0;
    frame_irq_d = 1'b0;
    if ((state_q == ARMED) && vblank_edge_c) begin
      copy_en_c   = 1'b1;
      frame_irq_d = 1'b1;
    end
  end

  // Table, counter and read-side next values
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (copy_en_c) active_d = shadow_q;
    if (entry_wr_c) shadow_d[wr_idx_c] = writedata[26:1];
    if (clear_wr_c) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_d[i][0] = 1'b0;
    end

    vcount_d      = VGA_VCOUNT;
    frame_count_d = frame_count_q + FCNT_W'(vblank_edge_c);

    rd_entry_d = '0;
    if (32'(rd_index) < NUM_SPRITES) rd_entry_d = active_q[rd_index[IDX_W-1:0]];

    readdata_d = readdata_q;
    if (bus_rd_c) begin
      readdata_d = '0;
      if (address == ADDR_STATUS) readdata_d = {frame_count_q, 15'b0, commit_pending};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      vcount_q      <= '0;
      frame_count_q <= '0;
      rd_entry_q    <= '0;
      readdata_q    <= '0;
      frame_irq_q   <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      rd_entry_q    <= rd_entry_d;
      readdata_q    <= readdata_d;
      frame_irq_q   <= frame_irq_d;
    end
  end

  assign commit_pending = (state_q == ARMED);
  assign frame_irq      = frame_irq_q;
  assign rd_entry       = rd_entry_q;
  assign readdata       = readdata_q;

endmodule

// File: tb/tb_sprite_table_loader.sv
// Bench for sprite_table_loader: directed scenarios plus random bus/vcount
// traffic, all checked every cycle against a table-level reference model.
module tb_sprite_table_loader;

  localparam int unsigned NUM = 16;
  localparam logic [9:0]  VBL = 10'd480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        chipselect, write, read;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  vga_vcount;
  logic [4:0]  rd_index;
  logic [25:0] rd_entry;
  logic        commit_pending, frame_irq;

  sprite_table_loader #(.NUM_SPRITES(NUM), .VBLANK_LINE(480)) dut (
    .clk(clk), .reset(rst_n), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_VCOUNT(vga_vcount), .rd_index(rd_index), .rd_entry(rd_entry),
    .commit_pending(commit_pending), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two plain tables, a pending flag and a frame counter.
  logic [25:0] m_shadow [32];
  logic [25:0] m_active [32];
  bit          m_pending;
  logic [15:0] m_fc;
  logic [9:0]  m_vc;
  logic [31:0] m_rd;
  logic [25:0] m_entry;
  bit          m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 0; m_fc = '0; m_vc = '0; m_rd = '0; m_entry = '0; m_irq = 0;
  endtask

  // Advance the model by one clock using the inputs that the edge sampled.
  task automatic model_step();
    bit       vb;
    bit       cwr;
    logic [4:0] idx;
    vb  = (m_vc != VBL) && (vga_vcount == VBL);
    cwr = chipselect && write && (address == 3'd1);
    m_entry = (32'(rd_index) < NUM) ? m_active[rd_index] : 26'h0;
    if (chipselect && read)
      m_rd = (address == 3'd3) ? {m_fc, 15'b0, m_pending} : 32'h0;
    m_irq = m_pending && vb;
    if (m_irq) m_active = m_shadow;
    if (chipselect && write && address == 3'd0) begin
      idx = writedata[31:27];
      if (32'(idx) < NUM) m_shadow[idx] = writedata[26:1];
    end
    if (chipselect && write && address == 3'd2)
      for (int i = 0; i < 32; i++) m_shadow[i][0] = 1'b0;
    m_pending = m_pending ? !vb : cwr;
    m_fc = m_fc + 16'(vb);
    m_vc = vga_vcount;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rd_entry", 32'(rd_entry), 32'(m_entry));
    check("readdata", readdata, m_rd);
    check("commit_pending", 32'(commit_pending), 32'(m_pending));
    check("frame_irq", 32'(frame_irq), 32'(m_irq));
  endtask

  task automatic bus(input logic [2:0] a, input logic w, input logic r, input logic [31:0] d);
    chipselect = 1'b1; write = w; read = r; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
  endtask

  task automatic vblank();
    vga_vcount = 10'd0;
    tick();
    vga_vcount = VBL;
    tick();
    vga_vcount = 10'd0;
  endtask

  // Asynchronous reset, asserted away from the clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pending", 32'(commit_pending), 32'h0);
    check("rst_irq", 32'(frame_irq), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_entry", 32'(rd_entry), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int irq_cnt;
    rst_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; vga_vcount = '0; rd_index = '0;
    model_reset();
    #3;
    check("por_pending", 32'(commit_pending), 32'h0);
    check("por_readdata", readdata, 32'h0);
    check("por_entry", 32'(rd_entry), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Lookups and status after reset
    for (int i = 0; i < 16; i++) begin
      rd_index = 5'(i);
      tick();
    end
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    check("status_after_reset", readdata, 32'h0);

    // Entry write, commit, sweep through the vblank line
    vga_vcount = 10'd100; tick();
    bus(3'd0, 1'b1, 1'b0, 32'h0A0C8040);
    bus(3'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("armed_after_commit", 32'(commit_pending), 32'h1);
    irq_cnt = 0;
    for (int v = 478; v <= 481; v++) begin
      vga_vcount = 10'(v);
      tick();
      irq_cnt += int'(frame_irq);
      if (v == 479) check("pending_before_480", 32'(commit_pending), 32'h1);
      if (v == 480) check("pending_at_480", 32'(commit_pending), 32'h0);
    end
    check("irq_pulses", 32'(irq_cnt), 32'h1);
    rd_index = 5'd1; tick();
    check("entry1_committed", 32'(rd_entry), 32'h0106_4020);

    // Commit in the same cycle as the 479->480 transition waits a frame
    bus(3'd0, 1'b1, 1'b0, {5'd1, 10'h2AA, 10'h155, 5'h1F, 1'b1, 1'b0});
    vga_vcount = 10'd479; tick();
    vga_vcount = VBL;
    bus(3'd1, 1'b1, 1'b0, 32'h0);
    check("late_commit_no_irq", 32'(frame_irq), 32'h0);
    for (int i = 0; i < 6; i++) tick();
    check("late_commit_still_pending", 32'(commit_pending), 32'h1);
    check("late_commit_no_copy", 32'(rd_entry), 32'h0106_4020);
    vblank();
    check("late_commit_applied_irq", 32'(frame_irq), 32'h1);
    tick();
    check("late_commit_entry", 32'(rd_entry), 32'({10'h2AA, 10'h155, 5'h1F, 1'b1}));

    // Out-of-range index write is dropped
    bus(3'd0, 1'b1, 1'b0, {5'd20, 26'h3FF_FFFF, 1'b1});
    bus(3'd1, 1'b1, 1'b0, 32'h0);
    vblank();
    rd_index = 5'd20; tick(); tick();
    check("oob_lookup", 32'(rd_entry), 32'h0);
    rd_index = 5'd4; tick(); tick();
    check("oob_no_alias", 32'(rd_entry), 32'h0);

    // Clear touches shadow only until the next commit
    for (int i = 0; i < 16; i++)
      bus(3'd0, 1'b1, 1'b0, {5'(i), 25'($urandom), 1'b1, 1'($urandom)});
    bus(3'd1, 1'b1, 1'b0, 32'h0);
    vblank();
    bus(3'd2, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      rd_index = 5'(i); tick();
    end
    rd_index = 5'd15; tick();
    check("clear_active_untouched", 32'(rd_entry[0]), 32'h1);
    bus(3'd1, 1'b1, 1'b0, 32'h0);
    vblank();
    for (int i = 0; i < 16; i++) begin
      rd_index = 5'(i); tick(); tick();
      check("clear_visible_bit", 32'(rd_entry[0]), 32'h0);
    end

    // Random traffic; vcount biased around the vblank line
    for (int n = 0; n < 4000; n++) begin
      chipselect = ($urandom_range(3) != 0);
      write      = 1'($urandom);
      read       = 1'($urandom);
      address    = ($urandom_range(2) == 0) ? 3'($urandom) : 3'($urandom_range(3));
      writedata  = $urandom;
      case ($urandom_range(3))
        0:       vga_vcount = 10'd479;
        1:       vga_vcount = VBL;
        default: vga_vcount = 10'($urandom_range(524));
      endcase
      rd_index = 5'($urandom);
      tick();
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0;

    // Reset while armed discards the commit and zeroes the active table
    vga_vcount = 10'd10;
    bus(3'd0, 1'b1, 1'b0, {5'd3, 26'h155_5555, 1'b0});
    bus(3'd1, 1'b1, 1'b0, 32'h0);
    do_reset();
    check("reset_drops_pending", 32'(commit_pending), 32'h0);
    vblank();
    check("reset_no_irq", 32'(frame_irq), 32'h0);
    rd_index = 5'd3; tick(); tick();
    check("reset_active_zero", 32'(rd_entry), 32'h0);

    // Frame counter wrap across 65536 edges from a fresh reset
    do_reset();
    rd_index = 5'd0;
    for (int e = 0; e < 65535; e++) begin
      vga_vcount = 10'd0; tick();
      vga_vcount = VBL;   tick();
    end
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    check("status_before_wrap", readdata, 32'hFFFF_0000);
    vga_vcount = 10'd0; tick();
    vga_vcount = VBL;   tick();
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    check("status_after_wrap", readdata, 32'h0);
    bus(3'd5, 1'b0, 1'b1, 32'h0);
    check("read_other_addr", readdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
